// File: rtl/motor_cmd_pkg.sv
// Shared constants for the motor command sequencer: FSM encoding, default
// timing parameters, speed-level limits and small speed-arithmetic helpers.
package motor_cmd_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DEAD = 2'd2;

    localparam logic [19:0] DEB_CYCLES_DEF  = 20'd20000;
    localparam logic [19:0] DEAD_CYCLES_DEF = 20'd50000;
    localparam logic [19:0] RAMP_CYCLES_DEF = 20'd10000;

    localparam logic [2:0] SPEED_MIN = 3'd0;
    localparam logic [2:0] SPEED_MAX = 3'd7;

    typedef struct packed {
        logic run;
        logic dir;
        logic up;
        logic dn;
    } key_evt_t;

    // Saturating target adjust; simultaneous up and down cancel each other.
    function automatic logic [2:0] tgt_adjust(input logic [2:0] tgt,
                                              input logic up, input logic dn);
        logic [2:0] res;
        res = tgt;
        if (up && !dn && tgt != SPEED_MAX)
            res = tgt + 3'd1;
        else if (dn && !up && tgt != SPEED_MIN)
            res = tgt - 3'd1;
        return res;
    endfunction

    function automatic logic [2:0] step_toward(input logic [2:0] cur,
                                               input logic [2:0] tgt);
        logic [2:0] res;
        res = cur;
        if (cur < tgt)
            res = cur + 3'd1;
        else if (cur > tgt)
            res = cur - 3'd1;
        return res;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser, stable-time debounce and registered press pulse for
// one active-low push-button.
module key_debounce
    import motor_cmd_pkg::*;
#(
    parameter logic [19:0] DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic div100_clk,
    input  logic s_rst_n,
    input  logic key_n,
    output logic press
);

    logic        sync_1;
    logic        sync_2;
    logic        level;
    logic        level_d;
    logic [19:0] stable_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge div100_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            sync_1     <= 1'b1;
            sync_2     <= 1'b1;
            level      <= 1'b1;
            level_d    <= 1'b1;
            stable_cnt <= '0;
            press      <= 1'b0;
        end else begin
            sync_1  <= key_n;
            sync_2  <= sync_1;
            level_d <= level;
            press   <= level_d & ~level;
            if (sync_2 != level) begin
                if (stable_cnt == DEB_CYCLES - 20'd1) begin
                    level      <= sync_2;
                    stable_cnt <= '0;
                end else begin
                    stable_cnt <= stable_cnt + 20'd1;
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/motor_cmd_seq.sv
// Motor command sequencer: debounced keys drive an IDLE/RUN/DEAD FSM with
// reversal dead-time and speed target. MOTOR_SOFT_START_EN selects ramped speed.
module motor_cmd_seq
    import motor_cmd_pkg::*;
#(
    parameter logic [19:0] DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter logic [19:0] DEAD_CYCLES = DEAD_CYCLES_DEF,
    parameter logic [19:0] RAMP_CYCLES = RAMP_CYCLES_DEF
) (
    input  logic       div100_clk,
    input  logic       s_rst_n,
    input  logic       key_run_n,
    input  logic       key_dir_n,
    input  logic       key_up_n,
    input  logic       key_dn_n,
    output logic       enable,
    output logic       direct,
    output logic [2:0] cnt,
    output logic       busy
);

    logic       run_p, dir_p, up_p, dn_p;
    key_evt_t   evt;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
        .div100_clk(div100_clk), .s_rst_n(s_rst_n), .key_n(key_run_n), .press(run_p));
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dir (
        .div100_clk(div100_clk), .s_rst_n(s_rst_n), .key_n(key_dir_n), .press(dir_p));
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .div100_clk(div100_clk), .s_rst_n(s_rst_n), .key_n(key_up_n), .press(up_p));
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
        .div100_clk(div100_clk), .s_rst_n(s_rst_n), .key_n(key_dn_n), .press(dn_p));

    assign evt = '{run: run_p, dir: dir_p, up: up_p, dn: dn_p};

    logic [1:0]  state, state_nxt;
    logic        direct_nxt;
    logic [2:0]  cnt_nxt, tgt, tgt_nxt, entry_cnt;
    logic [19:0] dead_cnt, dead_nxt;
`ifdef MOTOR_SOFT_START_EN
    logic [19:0] ramp_tmr, ramp_nxt;
    assign entry_cnt = SPEED_MIN;
`else
    assign entry_cnt = tgt;
`endif

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        direct_nxt = direct;
        cnt_nxt    = cnt;
        tgt_nxt    = tgt;
        dead_nxt   = dead_cnt;
`ifdef MOTOR_SOFT_START_EN
        ramp_nxt   = ramp_tmr;
`endif
        // Run and dir outrank speed keys; a lost up/down press is discarded.
        if (!evt.run && !evt.dir)
            tgt_nxt = tgt_adjust(tgt, evt.up, evt.dn);

        case (state)
            ST_IDLE: begin
                cnt_nxt  = SPEED_MIN;
                dead_nxt = '0;
                if (evt.run) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = entry_cnt;
`ifdef MOTOR_SOFT_START_EN
                    ramp_nxt  = '0;
`endif
                end else if (evt.dir) begin
                    direct_nxt = ~direct;
                end
            end
            ST_RUN: begin
                if (evt.run) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = SPEED_MIN;
                end else if (evt.dir) begin
                    state_nxt = ST_DEAD;
                    cnt_nxt   = SPEED_MIN;
                    dead_nxt  = '0;
                end else begin
`ifdef MOTOR_SOFT_START_EN
                    if (ramp_tmr == RAMP_CYCLES - 20'd1) begin
                        ramp_nxt = '0;
                        cnt_nxt  = step_toward(cnt, tgt);
                    end else begin
                        ramp_nxt = ramp_tmr + 20'd1;
                    end
`else
                    cnt_nxt = tgt;
`endif
                end
            end
            ST_DEAD: begin
                cnt_nxt = SPEED_MIN;
                if (evt.run) begin
                    state_nxt = ST_IDLE;
                    dead_nxt  = '0;
                end else if (dead_cnt == DEAD_CYCLES - 20'd1) begin
                    // Motor is still disabled here, so flipping direction is safe.
                    state_nxt  = ST_RUN;
                    direct_nxt = ~direct;
                    dead_nxt   = '0;
                    cnt_nxt    = entry_cnt;
`ifdef MOTOR_SOFT_START_EN
                    ramp_nxt   = '0;
`endif
                end else begin
                    dead_nxt = dead_cnt + 20'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = SPEED_MIN;
                dead_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge div100_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state    <= ST_IDLE;
            enable   <= 1'b0;
            busy     <= 1'b0;
            direct   <= 1'b0;
            cnt      <= SPEED_MIN;
            tgt      <= SPEED_MIN;
            dead_cnt <= '0;
`ifdef MOTOR_SOFT_START_EN
            ramp_tmr <= '0;
`endif
        end else begin
            state    <= state_nxt;
            enable   <= (state_nxt == ST_RUN);
            busy     <= (state_nxt == ST_DEAD);
            direct   <= direct_nxt;
            cnt      <= cnt_nxt;
            tgt      <= tgt_nxt;
            dead_cnt <= dead_nxt;
`ifdef MOTOR_SOFT_START_EN
            ramp_tmr <= ramp_nxt;
`endif
        end
    end

endmodule
